// File: rtl/linebuf_window_pkg.sv
// Shared widths, FSM encoding and small helpers for the sliding-window generator.
package linebuf_window_pkg;

  localparam int DWIDTH = 16;
  localparam int BSIZE  = 5;
  localparam int FSIZE  = 3;
  localparam int NBUF   = FSIZE - 1;
  localparam int RW     = (NBUF > 1) ? $clog2(NBUF) : 1;
  localparam int WBITS  = FSIZE * FSIZE * DWIDTH;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef logic signed [DWIDTH-1:0] pix_t;
  typedef logic [BSIZE-1:0]         addr_t;
  typedef logic [RW-1:0]            rot_t;

  // Line-buffer rotation pointer tracks row mod (FSIZE-1).
  function automatic rot_t rot_inc(input rot_t r);
    return (r == rot_t'(NBUF - 1)) ? '0 : r + 1'b1;
  endfunction

endpackage

// File: rtl/linebuf_window_if.sv
// Pixel-in / window-out bus between the fetch stage, the window generator and the conv core.
interface linebuf_window_if;
  import linebuf_window_pkg::*;

  logic             buf_start;
  logic [BSIZE:0]   img_size;
  logic             pixel_en;
  pix_t             pixel_in;
  logic [WBITS-1:0] win_data;
  logic             win_valid;
  logic             buf_busy;
  logic             buf_done;

  modport master (
    output buf_start, img_size, pixel_en, pixel_in,
    input  win_data, win_valid, buf_busy, buf_done
  );

  modport slave (
    input  buf_start, img_size, pixel_en, pixel_in,
    output win_data, win_valid, buf_busy, buf_done
  );

endinterface

// File: rtl/mem_linebuf.sv
// One image-row line buffer: synchronous write, registered read address, one-cycle read latency.
module mem_linebuf #(
  parameter int DW = 16,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          xrst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [AW-1:0] raddr_q;

  // NOTE: the storage array is deliberately not reset so it maps onto RAM; stale
  // contents are never exposed because only fully-refilled windows are flagged valid.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst)     raddr_q <= '0;
    else if (re_i) raddr_q <= raddr_i;
  end

  assign rdata_o = mem_q[raddr_q];

endmodule

// File: rtl/linebuf_window.sv
// Raster-order pixel stream in, FSIZE x FSIZE sliding windows out; owns line-buffer addressing.
module linebuf_window
  import linebuf_window_pkg::*;
(
  input  logic             clk,
  input  logic             xrst,
  linebuf_window_if.slave  bus
);

  state_e         state_q;
  logic [BSIZE:0] size_q;
  addr_t          col_q, row_q;
  rot_t           rot_q;

  logic  s1_vld_q, s1_elig_q, s1_last_q;
  pix_t  s1_pix_q;
  addr_t s1_col_q;
  rot_t  s1_rot_q;

  logic s2_vld_q, s2_elig_q, s2_last_q;

  pix_t             win_q [FSIZE][FSIZE];
  logic [WBITS-1:0] win_data_q;
  logic             win_valid_q, buf_done_q;

  pix_t             rd_data [NBUF];
  pix_t             new_col [FSIZE];
  logic [WBITS-1:0] win_flat;

  logic           accept, col_end, row_end;
  logic [BSIZE:0] size_m1;

  // buf_start has priority over a coincident pixel.
  assign accept  = (state_q == ST_RUN) && bus.pixel_en && !bus.buf_start;
  assign size_m1 = size_q - 1'b1;
  assign col_end = ({1'b0, col_q} == size_m1);
  assign row_end = ({1'b0, row_q} == size_m1);

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q <= ST_IDLE;
      size_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      rot_q   <= '0;
    end else if (bus.buf_start) begin
      state_q <= ST_RUN;
      size_q  <= bus.img_size;
      col_q   <= '0;
      row_q   <= '0;
      rot_q   <= '0;
    end else if (accept) begin
      if (col_end) begin
        col_q <= '0;
        row_q <= row_q + 1'b1;
        rot_q <= rot_inc(rot_q);
        if (row_end) state_q <= ST_IDLE;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      s1_vld_q  <= 1'b0;
      s1_elig_q <= 1'b0;
      s1_last_q <= 1'b0;
      s1_pix_q  <= '0;
      s1_col_q  <= '0;
      s1_rot_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_elig_q <= 1'b0;
      s2_last_q <= 1'b0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_elig_q <= (row_q >= addr_t'(FSIZE - 1)) && (col_q >= addr_t'(FSIZE - 1));
        s1_last_q <= col_end && row_end;
        s1_pix_q  <= bus.pixel_in;
        s1_col_q  <= col_q;
        s1_rot_q  <= rot_q;
      end
      s2_vld_q  <= s1_vld_q && !bus.buf_start;
      s2_elig_q <= s1_elig_q;
      s2_last_q <= s1_last_q;
    end
  end

  // Buffer rot holds the oldest row, so the new column is read rotated by rot.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    new_col = '{default: '0};
    for (int i = 0; i < NBUF; i++) begin
      for (int k = 0; k < NBUF; k++) begin
        if (k == (int'(s1_rot_q) + i) % NBUF) new_col[i] = rd_data[k];
      end
    end
    new_col[FSIZE-1] = s1_pix_q;
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      for (int i = 0; i < FSIZE; i++)
        for (int j = 0; j < FSIZE; j++)
          win_q[i][j] <= '0;
    end else if (s1_vld_q) begin
      for (int i = 0; i < FSIZE; i++) begin
        for (int j = 0; j < FSIZE - 1; j++) win_q[i][j] <= win_q[i][j+1];
        win_q[i][FSIZE-1] <= new_col[i];
      end
    end
  end

  always_comb begin
    win_flat = '0;
    for (int i = 0; i < FSIZE; i++)
      for (int j = 0; j < FSIZE; j++)
        win_flat[(i*FSIZE+j)*DWIDTH +: DWIDTH] = win_q[i][j];
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      win_data_q  <= '0;
      win_valid_q <= 1'b0;
      buf_done_q  <= 1'b0;
    end else begin
      if (s2_vld_q) win_data_q <= win_flat;
      win_valid_q <= s2_vld_q && s2_elig_q && !bus.buf_start;
      buf_done_q  <= s2_vld_q && s2_elig_q && s2_last_q && !bus.buf_start;
    end
  end

  // Write lags the read by one cycle, so the read at col returns the previous row.
  for (genvar k = 0; k < NBUF; k++) begin : g_buf
    mem_linebuf #(
      .DW (DWIDTH),
      .AW (BSIZE)
    ) u_mem (
      .clk     (clk),
      .xrst    (xrst),
      .we_i    (s1_vld_q && (s1_rot_q == rot_t'(k))),
      .waddr_i (s1_col_q),
      .wdata_i (s1_pix_q),
      .re_i    (accept),
      .raddr_i (col_q),
      .rdata_o (rd_data[k])
    );
  end

  assign bus.win_data  = win_data_q;
  assign bus.win_valid = win_valid_q;
  assign bus.buf_done  = buf_done_q;
  assign bus.buf_busy  = (state_q == ST_RUN);

endmodule
